hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have these parameters:
- RA_W, default 4: register-address width.
- NSTAGE, default 3, minimum 3: tracked post-decode stages, where stage 0 is E, stage 1 is M and stage NSTAGE-1 is W.
- MUL_CYC, default 4, minimum 1: execute latency of multicycle ops.

REQ-002 The block SHALL use FW_W = $clog2(NSTAGE) as the width of the forward selects.

REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, the single clock; all state on rising edge.
- reset, in, 1, asynchronous, active-low.
- dec_valid, in, 1, D holds a valid instruction.
- dec_ra1, in, RA_W, D source 1 address. dec_ra2, in, RA_W, D source 2 address.
- dec_use1, in, 1, source 1 is read. dec_use2, in, 1, source 2 is read.
- dec_rd, in, RA_W, D destination.
- dec_regwrite, in, 1, D writes dec_rd.
- dec_load, in, 1, D is a load.
- dec_mul, in, 1, D is a multicycle op.
- dec_pcwrite, in, 1, D writes the PC through the register file.
- br_taken_e, in, 1, branch in E resolved taken.
- stall_f, out, 1. stall_d, out, 1. flush_d, out, 1. flush_e, out, 1.
- fwd_a, out, FW_W, E operand A source: 0 = register file, k = result of stage k.
- fwd_b, out, FW_W, E operand B source, same encoding.
- mul_busy, out, 1, multicycle op occupying E.

Function
REQ-004 State:
- One entry per stage 0..NSTAGE-1: valid, rd, regwrite, load, pcwrite.
- Stage 0 additionally holds ra1, ra2, use1, use2.
- One down-counter, mcnt, of $clog2(MUL_CYC)+1 bits.

REQ-005 mul_busy SHALL equal (mcnt != 0).

REQ-006 Register address 2^RA_W-1 (PC) SHALL never match for forwarding or load-use.

REQ-007 ldstall SHALL be: dec_valid, and stage 0 valid with load and regwrite, and (dec_use1 and dec_ra1==stage0.rd, or dec_use2 and dec_ra2==stage0.rd).

REQ-008 pcw_inflight SHALL be: (dec_valid and dec_pcwrite), or any stage 0..NSTAGE-2 valid with pcwrite.

REQ-009 Control outputs SHALL follow strict priority, highest first:
- (a) br_taken_e: flush_d=1, flush_e=1, stall_f=0, stall_d=0.
- (b) mul_busy: stall_f=1, stall_d=1, flush_d=0, flush_e=0.
- (c) ldstall: stall_f=1, stall_d=1, flush_e=1, flush_d=0.
- (d) pcw_inflight: stall_f=1, flush_d=1, stall_d=0, flush_e=0.
- Otherwise all four outputs SHALL be 0.

REQ-010 fwd_a SHALL be the smallest k in 1..NSTAGE-1 with stage k valid, regwrite, rd==stage0.ra1 and stage0.use1; otherwise 0. fwd_b is defined the same way using ra2 and use2.

REQ-011 fwd_a and fwd_b SHALL be 0 when stage 0 is invalid.

REQ-012 Each edge while mul_busy:
- stage 0 holds;
- stage 1 loads a bubble;
- stage k loads stage k-1 for k ≥ 2;
- mcnt decrements.

REQ-013 Each edge while not mul_busy:
- stage k loads stage k-1 for k ≥ 1;
- stage 0 loads a bubble if flush_e or !dec_valid, otherwise the dec_* fields.

REQ-014 When a valid dec_mul instruction loads into stage 0 and MUL_CYC>1, mcnt SHALL load MUL_CYC-1; the op therefore occupies E for exactly MUL_CYC cycles.

REQ-015 With MUL_CYC=1, mul_busy SHALL remain 0 permanently.

REQ-016 A load reaching stage 1 whose rd matches a stage-0 source SHALL be unreachable; the bench asserts this.

REQ-017 Outputs SHALL be combinational from state and inputs, with no added latency.

Reset
REQ-018 While reset is low, all stage valids and mcnt SHALL clear immediately, and all outputs SHALL be driven 0.

REQ-019 When reset is asserted mid-multicycle, mcnt SHALL clear at once; the first instruction after release SHALL see no stall.

Verification (NSTAGE=3, MUL_CYC=4)
REQ-020 ALU chain: ADD r2 then SUB reads r2, then ORR reads r2 → fwd_a=1 on SUB in E; fwd_a=2 on ORR in E; stall_f=0 throughout.

REQ-021 Load-use: LDR r3 then ADD reads r3 → one cycle of stall_f=stall_d=flush_e=1; next cycle ADD in E with fwd_b=2.

REQ-022 MUL r4 then use of r4:
- mul_busy=1, stall_f=1, stall_d=1 for 3 cycles after the MUL enters E;
- M sees 3 bubbles;
- consumer in E gets fwd_a=1.

REQ-023 PC write: MOV r15 in D → stall_f=1, flush_d=1 for 3 cycles (D, E, M); deasserted when it reaches W.

REQ-024 Priority: br_taken_e=1 in the same cycle as pcw_inflight → flush_d=1, flush_e=1, stall_f=0, stall_d=0.

REQ-025 Reset low 1 cycle at mcnt=2 → mul_busy=0 and all outputs 0 immediately; after release, an ALU chain forwards normally.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Decode-side hazard bus: decoded instruction fields in, pipeline control and forward selects out.
interface hazard_scoreboard_if #(
    parameter int RA_W   = 4,
    parameter int NSTAGE = 3
);
    localparam int FW_W = $clog2(NSTAGE);

    logic            dec_valid;
    logic [RA_W-1:0] dec_ra1;
    logic [RA_W-1:0] dec_ra2;
    logic            dec_use1;
    logic            dec_use2;
    logic [RA_W-1:0] dec_rd;
    logic            dec_regwrite;
    logic            dec_load;
    logic            dec_mul;
    logic            dec_pcwrite;
    logic            br_taken_e;

    logic            stall_f;
    logic            stall_d;
    logic            flush_d;
    logic            flush_e;
    logic [FW_W-1:0] fwd_a;
    logic [FW_W-1:0] fwd_b;
    logic            mul_busy;

    modport master (
        output dec_valid, dec_ra1, dec_ra2, dec_use1, dec_use2, dec_rd,
               dec_regwrite, dec_load, dec_mul, dec_pcwrite, br_taken_e,
        input  stall_f, stall_d, flush_d, flush_e, fwd_a, fwd_b, mul_busy
    );

    modport slave (
        input  dec_valid, dec_ra1, dec_ra2, dec_use1, dec_use2, dec_rd,
               dec_regwrite, dec_load, dec_mul, dec_pcwrite, br_taken_e,
        output stall_f, stall_d, flush_d, flush_e, fwd_a, fwd_b, mul_busy
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight instructions from E to W and derives stalls, flushes and operand forwarding
// for the instruction in decode; multicycle ops hold E while a down-counter runs out.
module hazard_scoreboard #(
    parameter int RA_W    = 4,
    parameter int NSTAGE  = 3,
    parameter int MUL_CYC = 4
) (
    input logic                clk,
    input logic                reset,
    hazard_scoreboard_if.slave bus
);
    localparam int              FW_W    = $clog2(NSTAGE);
    localparam int              MCNT_W  = $clog2(MUL_CYC) + 1;
    localparam logic [RA_W-1:0] PC_ADDR = {RA_W{1'b1}};

    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rd;
        logic            regwrite;
        logic            load;
        logic            pcwrite;
    } stage_t;

    stage_t            stg [NSTAGE];
    logic [RA_W-1:0]   s0_ra1;
    logic [RA_W-1:0]   s0_ra2;
    logic              s0_use1;
    logic              s0_use2;
    logic [MCNT_W-1:0] mcnt;

    logic            mul_busy;
    logic            ld_hit1;
    logic            ld_hit2;
    logic            ldstall;
    logic            pcw_inflight;
    logic            stall_f;
    logic            stall_d;
    logic            flush_d;
    logic            flush_e;
    logic [FW_W-1:0] fwd_a;
    logic [FW_W-1:0] fwd_b;

    assign mul_busy = (mcnt != '0);

    // The PC alias is never a real data dependency, so it is excluded from every match.
    assign ld_hit1 = bus.dec_use1 && (bus.dec_ra1 == stg[0].rd) && (bus.dec_ra1 != PC_ADDR);
    assign ld_hit2 = bus.dec_use2 && (bus.dec_ra2 == stg[0].rd) && (bus.dec_ra2 != PC_ADDR);
    assign ldstall = bus.dec_valid && stg[0].valid && stg[0].load && stg[0].regwrite
                     && (ld_hit1 || ld_hit2);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        pcw_inflight = bus.dec_valid && bus.dec_pcwrite;
        for (int k = 0; k < NSTAGE - 1; k++) begin
            pcw_inflight = pcw_inflight || (stg[k].valid && stg[k].pcwrite);
        end
    end

    // Walk from the oldest stage down so the youngest matching producer wins.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int k = NSTAGE - 1; k >= 1; k--) begin
            if (stg[0].valid && s0_use1 && (s0_ra1 != PC_ADDR) && stg[k].valid
                && stg[k].regwrite && (stg[k].rd == s0_ra1)) begin
                fwd_a = FW_W'(k);
            end
            if (stg[0].valid && s0_use2 && (s0_ra2 != PC_ADDR) && stg[k].valid
                && stg[k].regwrite && (stg[k].rd == s0_ra2)) begin
                fwd_b = FW_W'(k);
            end
        end
    end

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (bus.br_taken_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (mul_busy) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
        end else if (ldstall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end else if (pcw_inflight) begin
            stall_f = 1'b1;
            flush_d = 1'b1;
        end
    end

    // State is already clear in reset; only the input-driven controls need masking.
    assign bus.stall_f  = reset && stall_f;
    assign bus.stall_d  = reset && stall_d;
    assign bus.flush_d  = reset && flush_d;
    assign bus.flush_e  = reset && flush_e;
    assign bus.fwd_a    = fwd_a;
    assign bus.fwd_b    = fwd_b;
    assign bus.mul_busy = mul_busy;

    // NOTE: all tracking state is a handful of flops, so every one is reset, not just the valids.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NSTAGE; k++) begin
                stg[k] <= '0;
            end
            s0_ra1  <= '0;
            s0_ra2  <= '0;
            s0_use1 <= 1'b0;
            s0_use2 <= 1'b0;
            mcnt    <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage sample its predecessor's old value.
            for (int k = NSTAGE - 1; k >= 2; k--) begin
                stg[k] <= stg[k-1];
            end
            if (mul_busy) begin
                stg[1] <= '0;
                mcnt   <= mcnt - MCNT_W'(1);
            end else begin
                stg[1] <= stg[0];
                if (flush_e || !bus.dec_valid) begin
                    stg[0]  <= '0;
                    s0_ra1  <= '0;
                    s0_ra2  <= '0;
                    s0_use1 <= 1'b0;
                    s0_use2 <= 1'b0;
                end else begin
                    stg[0]  <= '{valid:    1'b1,
                                 rd:       bus.dec_rd,
                                 regwrite: bus.dec_regwrite,
                                 load:     bus.dec_load,
                                 pcwrite:  bus.dec_pcwrite};
                    s0_ra1  <= bus.dec_ra1;
                    s0_ra2  <= bus.dec_ra2;
                    s0_use1 <= bus.dec_use1;
                    s0_use2 <= bus.dec_use2;
                    if (bus.dec_mul && (MUL_CYC > 1)) begin
                        mcnt <= MCNT_W'(MUL_CYC - 1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a per-cycle vector table plus a hand-written reset sequence.
module tb_hazard_scoreboard;
    localparam int RA_W    = 4;
    localparam int NSTAGE  = 3;
    localparam int MUL_CYC = 4;

    // Expected control nibble is {stall_f, stall_d, flush_d, flush_e}.
    localparam logic [3:0] C_NONE = 4'b0000;
    localparam logic [3:0] C_BR   = 4'b0011;
    localparam logic [3:0] C_MUL  = 4'b1100;
    localparam logic [3:0] C_LD   = 4'b1101;
    localparam logic [3:0] C_PCW  = 4'b1010;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.RA_W(RA_W), .NSTAGE(NSTAGE)) bus ();
    hazard_scoreboard_if #(.RA_W(RA_W), .NSTAGE(NSTAGE)) bus1 ();

    hazard_scoreboard #(.RA_W(RA_W), .NSTAGE(NSTAGE), .MUL_CYC(MUL_CYC)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    hazard_scoreboard #(.RA_W(RA_W), .NSTAGE(NSTAGE), .MUL_CYC(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    typedef struct packed {
        logic       valid;
        logic [3:0] ra1;
        logic [3:0] ra2;
        logic       use1;
        logic       use2;
        logic [3:0] rd;
        logic       regwrite;
        logic       load;
        logic       mul;
        logic       pcwrite;
    } dec_t;

    typedef struct {
        string      name;
        dec_t       d;
        logic       br;
        logic [3:0] ctl;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       mb;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic dec_t alu(input logic [3:0] rd, input logic [3:0] ra1, input logic [3:0] ra2,
                                 input logic u1, input logic u2);
        dec_t d;
        d          = '0;
        d.valid    = 1'b1;
        d.rd       = rd;
        d.ra1      = ra1;
        d.ra2      = ra2;
        d.use1     = u1;
        d.use2     = u2;
        d.regwrite = 1'b1;
        return d;
    endfunction

    function automatic dec_t ldr(input logic [3:0] rd, input logic [3:0] ra1);
        dec_t d;
        d      = alu(rd, ra1, 4'd0, 1'b1, 1'b0);
        d.load = 1'b1;
        return d;
    endfunction

    function automatic dec_t mul(input logic [3:0] rd, input logic [3:0] ra1, input logic [3:0] ra2);
        dec_t d;
        d     = alu(rd, ra1, ra2, 1'b1, 1'b1);
        d.mul = 1'b1;
        return d;
    endfunction

    function automatic dec_t movpc(input logic [3:0] ra1);
        dec_t d;
        d         = alu(4'd15, ra1, 4'd0, 1'b1, 1'b0);
        d.pcwrite = 1'b1;
        return d;
    endfunction

    task automatic add(input string n, input dec_t d, input logic br, input logic [3:0] ctl,
                       input logic [1:0] fa, input logic [1:0] fb, input logic mb);
        vec_t v;
        v.name = n;
        v.d    = d;
        v.br   = br;
        v.ctl  = ctl;
        v.fa   = fa;
        v.fb   = fb;
        v.mb   = mb;
        vecs.push_back(v);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) add("drain", '0, 1'b0, C_NONE, 2'd0, 2'd0, 1'b0);
    endtask

    task automatic drive(input dec_t d, input logic br);
        bus.dec_valid     = d.valid;    bus1.dec_valid     = d.valid;
        bus.dec_ra1       = d.ra1;      bus1.dec_ra1       = d.ra1;
        bus.dec_ra2       = d.ra2;      bus1.dec_ra2       = d.ra2;
        bus.dec_use1      = d.use1;     bus1.dec_use1      = d.use1;
        bus.dec_use2      = d.use2;     bus1.dec_use2      = d.use2;
        bus.dec_rd        = d.rd;       bus1.dec_rd        = d.rd;
        bus.dec_regwrite  = d.regwrite; bus1.dec_regwrite  = d.regwrite;
        bus.dec_load      = d.load;     bus1.dec_load      = d.load;
        bus.dec_mul       = d.mul;      bus1.dec_mul       = d.mul;
        bus.dec_pcwrite   = d.pcwrite;  bus1.dec_pcwrite   = d.pcwrite;
        bus.br_taken_e    = br;         bus1.br_taken_e    = br;
    endtask

    function automatic logic [3:0] ctl_of_dut();
        return {bus.stall_f, bus.stall_d, bus.flush_d, bus.flush_e};
    endfunction

    function automatic logic [3:0] ctl_of_dut1();
        return {bus1.stall_f, bus1.stall_d, bus1.flush_d, bus1.flush_e};
    endfunction

    // A load in M whose rd feeds the instruction in E must have been stalled away.
    always @(negedge clk) begin
        if (reset === 1'b1 && dut.stg[1].valid && dut.stg[1].load && dut.stg[1].regwrite
            && dut.stg[0].valid
            && ((dut.s0_use1 && dut.s0_ra1 == dut.stg[1].rd && dut.s0_ra1 != 4'hF)
             || (dut.s0_use2 && dut.s0_ra2 == dut.stg[1].rd && dut.s0_ra2 != 4'hF))) begin
            errors++;
            $display("FAIL ld_in_m_feeds_e: load rd=%0d in M with dependent op in E at %0t",
                     dut.stg[1].rd, $time);
        end
    end

    initial begin
        // ALU chain and youngest-producer / PC-alias forwarding
        add("alu_add",  alu(4'd2, 4'd0, 4'd1, 1'b1, 1'b1),  1'b0, C_NONE, 2'd0, 2'd0, 1'b0);
        add("alu_sub",  alu(4'd5, 4'd2, 4'd1, 1'b1, 1'b1),  1'b0, C_NONE, 2'd0, 2'd0, 1'b0);
        add("alu_orr",  alu(4'd6, 4'd2, 4'd3, 1'b1, 1'b1),  1'b0, C_NONE, 2'd1, 2'd0, 1'b0);
        add("alu_e_orr", '0,                                1'b0, C_NONE, 2'd2, 2'd0, 1'b0);
        add("alu_idle", '0,                                 1'b0, C_NONE, 2'd0, 2'd0, 1'b0);
        add("r7_first", alu(4'd7, 4'd0, 4'd0, 1'b0, 1'b0),  1'b0, C_NONE, 2'd0, 2'd0, 1'b0);
        add("r7_second", alu(4'd7, 4'd0, 4'd0, 1'b0, 1'b0), 1'b0, C_NONE, 2'd0, 2'd0, 1'b0);
        add("r7_reader", alu(4'd9, 4'd8, 4'd7, 1'b1, 1'b1), 1'b0, C_NONE, 2'd0, 2'd0, 1'b0);
        add("r7_youngest", '0,                              1'b0, C_NONE, 2'd0, 2'd1, 1'b0);
        add("w15_write", alu(4'd15, 4'd0, 4'd0, 1'b0, 1'b0), 1'b0, C_NONE, 2'd0, 2'd0, 1'b0);
        add("w15_reader", alu(4'd10, 4'd15, 4'd9, 1'b1, 1'b1), 1'b0, C_NONE, 2'd0, 2'd0, 1'b0);
        add("w15_nofwd", '0,                                1'b0, C_NONE, 2'd0, 2'd0, 1'b0);
        drain();
        // Load-use bubble and its exclusions
        add("ld_r3",    ldr(4'd3, 4'd1),                    1'b0, C_NONE, 2'd0, 2'd0, 1'b0);
        add("ld_use",   alu(4'd4, 4'd5, 4'd3, 1'b1, 1'b1),  1'b0, C_LD,   2'd0, 2'd0, 1'b0);
        add("ld_retry", alu(4'd4, 4'd5, 4'd3, 1'b1, 1'b1),  1'b0, C_NONE, 2'd0, 2'd0, 1'b0);
        add("ld_fwd_w", '0,                                 1'b0, C_NONE, 2'd0, 2'd2, 1'b0);
        add("ld_r15",   ldr(4'd15, 4'd1),                   1'b0, C_NONE, 2'd0, 2'd0, 1'b0);
        add("ld_r15_use", alu(4'd6, 4'd15, 4'd0, 1'b1, 1'b0), 1'b0, C_NONE, 2'd0, 2'd0, 1'b0);
        add("ld_r15_e", '0,                                 1'b0, C_NONE, 2'd0, 2'd0, 1'b0);
        add("ld_r8",    ldr(4'd8, 4'd1),                    1'b0, C_NONE, 2'd0, 2'd0, 1'b0);
        add("ld_r8_nouse", alu(4'd9, 4'd0, 4'd8, 1'b1, 1'b0), 1'b0, C_NONE, 2'd0, 2'd0, 1'b0);
        drain();
        // Multicycle op holds E for MUL_CYC cycles
        add("mul_r4",   mul(4'd4, 4'd1, 4'd2),              1'b0, C_NONE, 2'd0, 2'd0, 1'b0);
        add("mul_busy1", alu(4'd5, 4'd4, 4'd1, 1'b1, 1'b1), 1'b0, C_MUL,  2'd0, 2'd0, 1'b1);
        add("mul_busy2", alu(4'd5, 4'd4, 4'd1, 1'b1, 1'b1), 1'b0, C_MUL,  2'd0, 2'd0, 1'b1);
        add("mul_busy3", alu(4'd5, 4'd4, 4'd1, 1'b1, 1'b1), 1'b0, C_MUL,  2'd0, 2'd0, 1'b1);
        add("mul_done", alu(4'd5, 4'd4, 4'd1, 1'b1, 1'b1),  1'b0, C_NONE, 2'd0, 2'd0, 1'b0);
        add("mul_fwd",  '0,                                 1'b0, C_NONE, 2'd1, 2'd0, 1'b0);
        drain();
        // PC write in flight through D, E, M
        add("pcw_d",    movpc(4'd1),                        1'b0, C_PCW,  2'd0, 2'd0, 1'b0);
        add("pcw_e",    '0,                                 1'b0, C_PCW,  2'd0, 2'd0, 1'b0);
        add("pcw_m",    '0,                                 1'b0, C_PCW,  2'd0, 2'd0, 1'b0);
        add("pcw_w",    '0,                                 1'b0, C_NONE, 2'd0, 2'd0, 1'b0);
        drain();
        // Priority ordering between the four hazard sources
        add("br_over_pcw", movpc(4'd1),                     1'b1, C_BR,   2'd0, 2'd0, 1'b0);
        add("br_after",  '0,                                1'b0, C_NONE, 2'd0, 2'd0, 1'b0);
        add("br_ld_r3",  ldr(4'd3, 4'd1),                   1'b0, C_NONE, 2'd0, 2'd0, 1'b0);
        add("br_over_ld", alu(4'd4, 4'd3, 4'd0, 1'b1, 1'b0), 1'b1, C_BR,  2'd0, 2'd0, 1'b0);
        add("br_ld_gone", '0,                               1'b0, C_NONE, 2'd0, 2'd0, 1'b0);
        add("br_mul",    mul(4'd4, 4'd1, 4'd2),             1'b0, C_NONE, 2'd0, 2'd0, 1'b0);
        add("br_over_mul", '0,                              1'b1, C_BR,   2'd0, 2'd0, 1'b1);
        add("mul_over_pcw1", movpc(4'd1),                   1'b0, C_MUL,  2'd0, 2'd0, 1'b1);
        add("mul_over_pcw2", movpc(4'd1),                   1'b0, C_MUL,  2'd0, 2'd0, 1'b1);
        add("pcw_after_mul", movpc(4'd1),                   1'b0, C_PCW,  2'd0, 2'd0, 1'b0);
        add("pcw_after_e", '0,                              1'b0, C_PCW,  2'd0, 2'd0, 1'b0);
        add("pcw_after_m", '0,                              1'b0, C_PCW,  2'd0, 2'd0, 1'b0);
        add("pcw_after_w", '0,                              1'b0, C_NONE, 2'd0, 2'd0, 1'b0);
        add("lp_ld_r3",  ldr(4'd3, 4'd1),                   1'b0, C_NONE, 2'd0, 2'd0, 1'b0);
        add("ld_over_pcw", movpc(4'd3),                     1'b0, C_LD,   2'd0, 2'd0, 1'b0);
        add("lp_pcw_d",  movpc(4'd3),                       1'b0, C_PCW,  2'd0, 2'd0, 1'b0);
        add("lp_pcw_e",  '0,                                1'b0, C_PCW,  2'd2, 2'd0, 1'b0);
        add("lp_pcw_m",  '0,                                1'b0, C_PCW,  2'd0, 2'd0, 1'b0);
        add("lp_pcw_w",  '0,                                1'b0, C_NONE, 2'd0, 2'd0, 1'b0);
        drain();

        // Outputs must be forced low during reset even with hazardous inputs applied.
        reset = 1'b0;
        drive(movpc(4'd1), 1'b1);
        #2;
        check("rst_ctl",  8'(ctl_of_dut()), 8'(C_NONE));
        check("rst_fwd",  8'({bus.fwd_a, bus.fwd_b}), 8'd0);
        check("rst_busy", 8'(bus.mul_busy), 8'd0);
        check("rst_ctl_mc1", 8'(ctl_of_dut1()), 8'(C_NONE));
        @(posedge clk);
        #1;
        reset = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].d, vecs[i].br);
            @(negedge clk);
            check({vecs[i].name, ".ctl"},  8'(ctl_of_dut()), 8'(vecs[i].ctl));
            check({vecs[i].name, ".fwd_a"}, 8'(bus.fwd_a), 8'(vecs[i].fa));
            check({vecs[i].name, ".fwd_b"}, 8'(bus.fwd_b), 8'(vecs[i].fb));
            check({vecs[i].name, ".busy"}, 8'(bus.mul_busy), 8'(vecs[i].mb));
            check({vecs[i].name, ".mc1_busy"}, 8'(bus1.mul_busy), 8'd0);
            @(posedge clk);
            #1;
        end

        // Reset pulse while the multicycle counter sits at 2
        drive(mul(4'd4, 4'd1, 4'd2), 1'b0);
        @(negedge clk);
        check("rm_issue_busy", 8'(bus.mul_busy), 8'd0);
        @(posedge clk);
        #1;
        drive('0, 1'b0);
        @(negedge clk);
        check("rm_busy_cnt3", 8'(bus.mul_busy), 8'd1);
        @(posedge clk);
        #1;
        check("rm_busy_cnt2", 8'(bus.mul_busy), 8'd1);
        drive(movpc(4'd1), 1'b1);
        reset = 1'b0;
        #1;
        check("rm_ctl",  8'(ctl_of_dut()), 8'(C_NONE));
        check("rm_fwd",  8'({bus.fwd_a, bus.fwd_b}), 8'd0);
        check("rm_busy", 8'(bus.mul_busy), 8'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(alu(4'd2, 4'd0, 4'd1, 1'b1, 1'b1), 1'b0);
        @(negedge clk);
        check("post_rst_add_ctl",  8'(ctl_of_dut()), 8'(C_NONE));
        check("post_rst_add_busy", 8'(bus.mul_busy), 8'd0);
        @(posedge clk);
        #1;
        drive(alu(4'd5, 4'd2, 4'd1, 1'b1, 1'b1), 1'b0);
        @(negedge clk);
        check("post_rst_sub_ctl", 8'(ctl_of_dut()), 8'(C_NONE));
        @(posedge clk);
        #1;
        drive('0, 1'b0);
        @(negedge clk);
        check("post_rst_fwd_a", 8'(bus.fwd_a), 8'd1);
        check("post_rst_e_ctl", 8'(ctl_of_dut()), 8'(C_NONE));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
